// File: rtl/tx_dma_arbiter.sv
// Round-robin arbiter moving words from four DMA request channels into four depth-4 TX FIFOs.
// Define TX_DMA_ARB_BURST_EN to let a granted channel keep the grant for up to BURST_LEN beats.
module tx_dma_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arb_en,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data [3:0],
  output logic [3:0]  req_ready,
  input  logic [2:0]  fifo_count [3:0],
  output logic [3:0]  push_en,
  output logic [31:0] push_data,
  output logic [15:0] beat_count [3:0]
);

  // Handshake: a beat on channel i transfers in any cycle where req_valid[i] & req_ready[i];
  // req_ready is combinational, at most one bit high, and the source must hold data while valid.

  if ((BURST_LEN < 1) || (BURST_LEN > 8)) begin : g_bad_burst_len
    $error("tx_dma_arbiter: BURST_LEN must be within 1..8");
  end

`ifdef TX_DMA_ARB_BURST_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;
  localparam int LP_BURST_LEN = BURST_LEN;
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0} state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_last;
  logic [1:0]  w_last_nxt;
  logic [3:0]  r_push_en;
  logic [31:0] r_push_data;
  logic [15:0] r_beat_cnt [3:0];

  logic [3:0]  w_elig;
  logic [3:0]  w_ready;
  logic [3:0]  w_accept;
  logic [1:0]  w_arb_sel;
  logic        w_arb_hit;
  logic [1:0]  w_sel;
  logic        w_rearb;

`ifdef TX_DMA_ARB_BURST_EN
  logic [1:0]  r_owner;
  logic [1:0]  w_owner_nxt;
  logic [2:0]  r_burst;
  logic [2:0]  w_burst_nxt;
`endif

  // A push already in flight counts against the FIFO so a count-3 FIFO takes only one beat.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = ~rst & arb_en & req_valid[i] &
                  (({1'b0, fifo_count[i]} + {3'b000, r_push_en[i]}) < 4'd4);
    end
  end

  // Search last+4 down to last+1 so the lowest offset (highest priority) is written last.
  always_comb begin
    w_arb_sel = r_last;
    w_arb_hit = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (w_elig[r_last + 2'(k)]) begin
        w_arb_hit = 1'b1;
        w_arb_sel = r_last + 2'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_sel       = w_arb_sel;
    w_last_nxt  = r_last;
    w_rearb     = 1'b1;
`ifdef TX_DMA_ARB_BURST_EN
    w_owner_nxt = r_owner;
    w_burst_nxt = r_burst;
    if ((r_state == S_GRANT) && w_elig[r_owner]) begin
      w_rearb     = 1'b0;
      w_ready     = 4'b0001 << r_owner;
      w_sel       = r_owner;
      w_burst_nxt = r_burst + 3'd1;
      if (({1'b0, r_burst} + 4'd1) >= 4'(LP_BURST_LEN)) begin
        w_state_nxt = S_IDLE;
      end
    end
`endif
    // Losing the owner or hitting the limit re-arbitrates in the same cycle: no bubble.
    if (w_rearb) begin
      w_state_nxt = S_IDLE;
      if (w_arb_hit) begin
        w_ready    = 4'b0001 << w_arb_sel;
        w_last_nxt = w_arb_sel;
`ifdef TX_DMA_ARB_BURST_EN
        w_owner_nxt = w_arb_sel;
        w_burst_nxt = 3'd1;
        if (LP_BURST_LEN > 1) begin
          w_state_nxt = S_GRANT;
        end
`endif
      end
    end
  end

  assign w_accept = w_ready & req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd3;
      r_push_en   <= '0;
      r_push_data <= '0;
      for (int i = 0; i < 4; i++) begin
        r_beat_cnt[i] <= '0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_push_en <= w_accept;
      if (|w_accept) begin
        r_push_data <= req_data[w_sel];
      end
      for (int i = 0; i < 4; i++) begin
        if (w_accept[i]) begin
          r_beat_cnt[i] <= r_beat_cnt[i] + 16'd1;
        end
      end
    end
  end

`ifdef TX_DMA_ARB_BURST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= '0;
      r_burst <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_burst <= w_burst_nxt;
    end
  end
`endif

  assign req_ready  = w_ready;
  assign push_en    = r_push_en;
  assign push_data  = r_push_data;
  assign beat_count = r_beat_cnt;

endmodule

// File: tb/tb_tx_dma_arbiter.sv
// Directed bench for tx_dma_arbiter: scripted sources, a push scoreboard and counter checks.
// Expectations follow TX_DMA_ARB_BURST_EN when it is defined for the build.
module tb_tx_dma_arbiter;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data [3:0];
  logic [3:0]  req_ready;
  logic [2:0]  fifo_count [3:0];
  logic [3:0]  push_en;
  logic [31:0] push_data;
  logic [15:0] beat_count [3:0];

  int          src_left [4];
  logic [15:0] src_seq [4];
  logic [15:0] exp_seq [4];
  logic [15:0] exp_cnt [4];
  logic [35:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  bit          sb_on;
  int          n_bulk;

  tx_dma_arbiter #(.BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .arb_en     (arb_en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_count (fifo_count),
    .push_en    (push_en),
    .push_data  (push_data),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int ch, input logic [15:0] n);
    return {4'(ch), 12'h000, n};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input int ch);
    exp_q.push_back({4'(1 << ch), mk(ch, exp_seq[ch])});
    exp_seq[ch]++;
    exp_cnt[ch]++;
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (src_left[i] > 0);
      req_data[i]  = mk(i, src_seq[i]);
    end
  endtask

  // One clock: sample the handshake at negedge, advance sources after the edge, score pushes.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    chk("ready_legal", 64'($onehot0(req_ready) && ((req_ready & ~req_valid) == 4'd0)), 64'd1);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        src_seq[i]++;
        src_left[i]--;
      end
    end
    refresh();
    if (sb_on && (push_en !== 4'd0)) begin
      if (exp_q.size() == 0) chk("push_spurious", {push_en, push_data}, 64'd0);
      else chk("push", {push_en, push_data}, exp_q.pop_front());
    end
  endtask

  task automatic chk_counts(input string tag);
    for (int i = 0; i < 4; i++) chk(tag, beat_count[i], exp_cnt[i]);
  endtask

  initial begin
    rst    = 1'b1;
    arb_en = 1'b1;
    sb_on  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fifo_count[i] = 3'd0;
      src_left[i]   = 1;
      src_seq[i]    = 16'd0;
      exp_seq[i]    = 16'd0;
      exp_cnt[i]    = 16'd0;
    end
    refresh();

    // Reset state, with every channel requesting.
    #12;
    chk("rst_ready", req_ready, 4'd0);
    chk("rst_push_en", push_en, 4'd0);
    chk("rst_push_data", push_data, 32'd0);
    chk_counts("rst_count");
    for (int i = 0; i < 4; i++) src_left[i] = 0;
    refresh();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Arbitration with empty FIFOs.
`ifdef TX_DMA_ARB_BURST_EN
    src_left[0] = BL + 2;
    src_left[1] = BL;
    for (int k = 0; k < BL; k++) exp_push(0);
    for (int k = 0; k < BL; k++) exp_push(1);
    exp_push(0);
    exp_push(0);
    refresh();
    repeat (3 * BL - 2) step();
`else
    for (int i = 0; i < 4; i++) src_left[i] = 2;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) exp_push(i);
    refresh();
    repeat (8) step();
`endif
    chk("arb_drain", 64'(exp_q.size()), 64'd0);
    chk_counts("arb_count");

    // FIFO at count 3 takes exactly one beat.
    fifo_count[2] = 3'd3;
    src_left[2]   = 2;
    exp_push(2);
    refresh();
    step();
    #1;
    chk("full_ready_inflight", req_ready, 4'd0);
    fifo_count[2] = 3'd4;
    repeat (2) begin
      step();
      chk("full_nopush", push_en, 4'd0);
      chk("full_ready", req_ready, 4'd0);
    end
    fifo_count[2] = 3'd2;
    #1;
    chk("refill_ready", req_ready, 4'b0100);
    exp_push(2);
    step();
    fifo_count[2] = 3'd0;
    chk("full_drain", 64'(exp_q.size()), 64'd0);

    // arb_en falls right after an accepted beat.
    src_left[1] = 5;
    exp_push(1);
    refresh();
    step();
    arb_en = 1'b0;
    #1;
    chk("arboff_ready", req_ready, 4'd0);
    chk("arboff_inflight", push_en, 4'b0010);
    repeat (3) begin
      step();
      chk("arboff_nopush", push_en, 4'd0);
    end
    arb_en = 1'b1;
    for (int k = 0; k < 4; k++) exp_push(1);
    repeat (4) step();
    chk("arbon_drain", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream, then the first grant goes to ch0.
    sb_on = 1'b0;
    for (int i = 0; i < 4; i++) src_left[i] = 10;
    refresh();
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("midrst_push_en", push_en, 4'd0);
    chk("midrst_ready", req_ready, 4'd0);
    for (int i = 0; i < 4; i++) chk("midrst_count", beat_count[i], 16'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_cnt[i]  = 16'd0;
      exp_seq[i]  = src_seq[i];
      src_left[i] = 1;
    end
    refresh();
    @(posedge clk);
    #1;
    chk("midrst_hold_push", push_en, 4'd0);
    rst   = 1'b0;
    sb_on = 1'b1;
    for (int i = 0; i < 4; i++) exp_push(i);
    repeat (4) step();
    chk("postrst_drain", 64'(exp_q.size()), 64'd0);
    chk_counts("postrst_count");

    // Counter wrap on ch1.
    n_bulk      = 65535 - int'(exp_cnt[1]);
    src_left[1] = n_bulk;
    for (int k = 0; k < n_bulk; k++) exp_push(1);
    refresh();
    repeat (n_bulk) step();
    chk("bulk_drain", 64'(exp_q.size()), 64'd0);
    chk("wrap_pre", beat_count[1], 16'hFFFF);
    src_left[1] = 1;
    exp_push(1);
    refresh();
    step();
    chk("wrap", beat_count[1], 16'h0000);
    chk_counts("wrap_count");
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_dma_arbiter.md
TX_DMA_ARBITER -- requirements
Module: tx_dma_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning max consecutive beats per grant (range 1..8).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port arb_en  input  1  arbitration enable; 0 = no new beats accepted.
REQ-005 SHALL have port req_valid  input  4  per-channel word available (channel i targets TX FIFO i).
REQ-006 SHALL have port req_data  input  4x32 (unpacked [3:0])  per-channel data word.
REQ-007 SHALL have port req_ready  output  4  one-hot or zero; beat accepted when req_valid[i] & req_ready[i].
REQ-008 SHALL have port fifo_count  input  4x3 (unpacked [3:0])  occupancy of each depth-4 TX FIFO.
REQ-009 SHALL have port push_en  output  4  registered one-hot push strobe to FIFO i.
REQ-010 SHALL have port push_data  output  32  registered data for the pushed FIFO.
REQ-011 SHALL have port beat_count  output  4x16 (unpacked [3:0])  per-channel accepted-beat counter.

Function
REQ-012 SHALL make channel i eligible when req_valid[i]=1, arb_en=1, and fifo_count[i] + (push_en[i] ? 1 : 0) < 4.
REQ-013 SHALL set req_ready combinationally: at most one bit high, and only for an eligible channel.
REQ-014 SHALL, on an accepted beat for channel i, drive push_en[i]=1 and push_data=req_data[i] on the following cycle (latency 1); otherwise push_en=0 and push_data holds its last value.
REQ-015 SHALL implement states IDLE and GRANT with a 2-bit owner register and a last-granted pointer last (reset 3).
REQ-016 SHALL, in IDLE, select the first eligible channel searching last+1, last+2, last+3, last (mod 4), accept one beat from it, set owner and last to it, and go to GRANT if bursting is enabled and BURST_LEN>1.
REQ-017 SHALL, in GRANT, accept beats only from owner while owner is eligible and the beats in this grant are fewer than BURST_LEN.
REQ-018 SHALL return from GRANT to IDLE in the same cycle owner becomes ineligible or the burst limit is reached; that cycle re-arbitrates as in REQ-016, so no bubble is inserted.
REQ-019 SHALL use a 3-bit burst counter, loaded to 1 on grant and incremented per accepted beat.
REQ-020 SHALL increment beat_count[i] by 1 per accepted beat, wrapping 0xFFFF to 0x0000.
REQ-021 SHALL, when arb_en falls, accept no further beats, still issue any already-accepted push next cycle, and enter IDLE.
REQ-022 SHALL never accept a beat that would overflow a FIFO, including back-to-back beats to a FIFO at count 3 (the second is blocked by REQ-012).

Reset
REQ-023 SHALL, on rst=1 and regardless of clk, clear push_en, push_data, beat_count, owner and burst counter to 0, set last=3, and set state to IDLE.
REQ-024 SHALL drive req_ready=0 while rst=1.
REQ-025 SHALL discard a beat accepted in the cycle reset asserts, producing no push after reset.

Configuration
REQ-026 SHALL honour macro TX_DMA_ARB_BURST_EN.
REQ-027 SHALL, when TX_DMA_ARB_BURST_EN is defined, grant bursts up to BURST_LEN per REQ-017/018.
REQ-028 SHALL, when TX_DMA_ARB_BURST_EN is undefined, treat BURST_LEN as 1: never enter GRANT, re-arbitrate every beat in strict round-robin, and omit the GRANT state and burst counter.

Verification
REQ-029 SHALL cover reset: rst pulse mid-stream -> push_en=0, beat_count all 0, next grant goes to ch0.
REQ-030 SHALL cover round-robin, burst macro undefined: all 4 channels valid, FIFOs empty -> pushes to ch0,1,2,3,0,... on consecutive cycles.
REQ-031 SHALL cover bursting: macro defined, BURST_LEN=4, ch0 and ch1 valid -> 4 pushes to ch0, then 4 pushes to ch1, with no idle cycle between them.
REQ-032 SHALL cover full blocking: fifo_count[2]=3, only ch2 valid -> exactly one push, then req_ready[2]=0 until fifo_count[2] drops.
REQ-033 SHALL cover arb_en deassert: arb_en cleared after an accepted beat -> that push appears next cycle, then no further pushes.
REQ-034 SHALL cover counter wrap: beat_count[1] preset by 0xFFFF beats, one more beat -> beat_count[1]=0x0000.
